// File: rtl/online_r4_pkg.sv
// Shared constants for the radix-4 online arithmetic datapath:
// digit encoding and the converter state encoding.
package online_r4_pkg;
   localparam int RADIX     = 4;
   localparam int DIGIT_W   = 3;
   localparam int DIGIT_MIN = -3;
   localparam int DIGIT_MAX = 3;
   localparam logic [DIGIT_W-1:0] ILLEGAL_DIGIT = 3'b100;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SKIP = 2'd1,
      CONV = 2'd2,
      DONE = 2'd3
   } conv_state_t;

   // The single encoding with no legal meaning: -4 does not fit the {-3..3} set.
   function automatic logic is_illegal(input logic [DIGIT_W-1:0] d);
      return d == ILLEGAL_DIGIT;
   endfunction
endpackage

// File: rtl/online_to_binary_r4_if.sv
// Digit-stream in / finished-result out bundle of the online-to-binary converter.
interface online_to_binary_r4_if #(
   parameter int N_DIGITS = 8
) ();
   import online_r4_pkg::*;
   localparam int RW = 2*N_DIGITS + 1;

   logic               start;
   logic               en;
   logic [DIGIT_W-1:0] di;
   logic               ack;
   logic [RW-1:0]      result;
   logic               result_valid;
   logic               busy;
   logic               digit_err;

   // Upstream adder / readout side.
   modport master (
      output start, en, di, ack,
      input  result, result_valid, busy, digit_err
   );

   // The converter itself.
   modport slave (
      input  start, en, di, ack,
      output result, result_valid, busy, digit_err
   );
endinterface

// File: rtl/otf_step_r4.sv
// One radix-4 on-the-fly conversion step. Keeps Q and QM = Q-1 so that a
// negative digit never needs a borrow: it just appends to QM instead.
module otf_step_r4 #(
   parameter int RW = 17
) (
   input  logic [RW-1:0] q,
   input  logic [RW-1:0] qm,
   input  logic [2:0]    d,
   output logic [RW-1:0] q_next,
   output logic [RW-1:0] qm_next
);
   logic [RW-1:0] q4, qm4, dx;
   logic          d_neg, d_pos;

   assign q4    = {q[RW-3:0], 2'b00};
   assign qm4   = {qm[RW-3:0], 2'b00};
   assign dx    = {{(RW-3){d[2]}}, d};
   assign d_neg = d[2];
   assign d_pos = !d[2] && (d != 3'd0);

   // Select the appended prefix and the digit (or its radix complement).
   always_comb begin
      q_next  = d_neg ? (qm4 + RW'(4) + dx) : (q4 + dx);
      qm_next = d_pos ? (q4 + dx - RW'(1)) : (qm4 + RW'(3) + dx);
   end
endmodule

// File: rtl/online_to_binary_r4.sv
// Radix-4 signed-digit stream (MSD first) to two's-complement converter.
// Drops DELAY leading enabled digits, converts N_DIGITS digits on the fly and
// raises result_valid on the edge that samples the last digit.
module online_to_binary_r4 #(
   parameter int N_DIGITS = 8,
   parameter int DELAY    = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   online_to_binary_r4_if.slave  bus
);
   import online_r4_pkg::*;

   localparam int RW  = 2*N_DIGITS + 1;
   localparam int SKW = $clog2(DELAY + 2);
   localparam int DCW = $clog2(N_DIGITS + 1);

   conv_state_t        state;
   logic [RW-1:0]      q, qm, q_next, qm_next;
   logic [SKW-1:0]     skip_cnt;
   logic [DCW-1:0]     dig_cnt;
   logic [DIGIT_W-1:0] d_eff;
   logic               d_bad;

   // An illegal digit is flagged and then converted as zero.
   assign d_bad = is_illegal(bus.di);
   assign d_eff = d_bad ? '0 : bus.di;

   otf_step_r4 #(.RW(RW)) u_step (
      .q       (q),
      .qm      (qm),
      .d       (d_eff),
      .q_next  (q_next),
      .qm_next (qm_next)
   );

   // Control FSM plus the Q/QM accumulators; start overrides everything.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state            <= IDLE;
         q                <= '0;
         qm               <= '1;
         skip_cnt         <= '0;
         dig_cnt          <= '0;
         bus.result       <= '0;
         bus.result_valid <= 1'b0;
         bus.busy         <= 1'b0;
         bus.digit_err    <= 1'b0;
      end else if (bus.start) begin
         state            <= (DELAY > 0) ? SKIP : CONV;
         q                <= '0;
         qm               <= '1;
         skip_cnt         <= SKW'(DELAY);
         dig_cnt          <= '0;
         bus.result_valid <= 1'b0;
         bus.busy         <= 1'b1;
         bus.digit_err    <= 1'b0;
      end else begin
         case (state)
            SKIP: if (bus.en) begin
               skip_cnt <= skip_cnt - SKW'(1);
               if (skip_cnt == SKW'(1)) state <= CONV;
            end
            CONV: if (bus.en) begin
               q       <= q_next;
               qm      <= qm_next;
               dig_cnt <= dig_cnt + DCW'(1);
               if (d_bad) bus.digit_err <= 1'b1;
               if (dig_cnt == DCW'(N_DIGITS - 1)) begin
                  state            <= DONE;
                  bus.result       <= q_next;
                  bus.result_valid <= 1'b1;
                  bus.busy         <= 1'b0;
               end
            end
            DONE: if (bus.ack) begin
               state            <= IDLE;
               bus.result_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_online_to_binary_r4.sv
// Bench for online_to_binary_r4: two instances (DELAY=0 and DELAY=1, both
// N_DIGITS=4) share one directed stimulus stream. A per-instance model derives
// the result as sum(d_k * 4^(N-k)) and is compared every cycle; directed literal
// checks pin both the model and the DUTs.
module tb_online_to_binary_r4;
   localparam int N  = 4;
   localparam int RW = 2*N + 1;
   localparam int DLY [2] = '{0, 1};

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       start = 1'b0, en = 1'b0, ack = 1'b0;
   logic [2:0] di = '0;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   online_to_binary_r4_if #(.N_DIGITS(N)) bus0 ();
   online_to_binary_r4_if #(.N_DIGITS(N)) bus1 ();

   assign bus0.start = start;
   assign bus0.en    = en;
   assign bus0.di    = di;
   assign bus0.ack   = ack;
   assign bus1.start = start;
   assign bus1.en    = en;
   assign bus1.di    = di;
   assign bus1.ack   = ack;

   online_to_binary_r4 #(.N_DIGITS(N), .DELAY(0)) u0 (.clk(clk), .reset(reset), .bus(bus0));
   online_to_binary_r4 #(.N_DIGITS(N), .DELAY(1)) u1 (.clk(clk), .reset(reset), .bus(bus1));

   // Behavioural model state per instance.
   bit            m_act   [2];
   bit            m_valid [2];
   bit            m_err   [2];
   int            m_skip  [2];
   int            m_cnt   [2];
   int            m_val   [2];
   logic [RW-1:0] m_res   [2];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: count down the skip window, then accumulate weighted digits.
   always @(posedge clk or posedge reset) begin
      for (int i = 0; i < 2; i++) begin
         if (reset) begin
            m_act[i] = 0; m_valid[i] = 0; m_err[i] = 0;
            m_skip[i] = 0; m_cnt[i] = 0; m_val[i] = 0; m_res[i] = '0;
         end else if (start) begin
            m_act[i] = 1; m_valid[i] = 0; m_err[i] = 0;
            m_skip[i] = DLY[i]; m_cnt[i] = 0; m_val[i] = 0;
         end else if (m_act[i] && en) begin
            if (m_skip[i] > 0) m_skip[i]--;
            else begin
               int d;
               d = int'($signed(di));
               if (di == 3'b100) begin d = 0; m_err[i] = 1; end
               m_val[i] += d * (4 ** (N - 1 - m_cnt[i]));
               m_cnt[i]++;
               if (m_cnt[i] == N) begin
                  m_act[i] = 0; m_valid[i] = 1; m_res[i] = m_val[i][RW-1:0];
               end
            end
         end else if (m_valid[i] && ack) begin
            m_valid[i] = 0;
         end
      end
   end

   // Every-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      chk("u0.result",       32'(bus0.result),       32'(m_res[0]));
      chk("u0.result_valid", 32'(bus0.result_valid), 32'(m_valid[0]));
      chk("u0.busy",         32'(bus0.busy),         32'(m_act[0]));
      chk("u0.digit_err",    32'(bus0.digit_err),    32'(m_err[0]));
      chk("u1.result",       32'(bus1.result),       32'(m_res[1]));
      chk("u1.result_valid", 32'(bus1.result_valid), 32'(m_valid[1]));
      chk("u1.busy",         32'(bus1.busy),         32'(m_act[1]));
      chk("u1.digit_err",    32'(bus1.digit_err),    32'(m_err[1]));
   end

   task automatic cyc(input bit s, input bit e, input int d, input bit a);
      @(negedge clk);
      start = s; en = e; di = 3'(d); ack = a;
   endtask

   task automatic run4(input int a, input int b, input int c, input int d);
      cyc(1, 0, 0, 0);
      cyc(0, 1, a, 0);
      cyc(0, 1, b, 0);
      cyc(0, 1, c, 0);
      cyc(0, 1, d, 0);
      cyc(0, 0, 0, 0);
   endtask

   task automatic do_ack();
      cyc(0, 0, 0, 1);
      cyc(0, 0, 0, 0);
   endtask

   initial begin
      #1 reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      chk("reset result", 32'(bus0.result), 32'h0);
      chk("reset valid",  32'(bus0.result_valid), 32'h0);
      chk("reset busy",   32'(bus0.busy), 32'h0);
      chk("reset err",    32'(bus0.digit_err), 32'h0);

      // 1,-1,0,2 -> +50; valid must not be up before the 4th digit edge.
      cyc(1, 0, 0, 0);
      cyc(0, 1, 1, 0);
      cyc(0, 1, -1, 0);
      cyc(0, 1, 0, 0);
      cyc(0, 1, 2, 0);
      chk("valid before last", 32'(bus0.result_valid), 32'h0);
      cyc(0, 0, 0, 0);
      chk("+50 valid",  32'(bus0.result_valid), 32'h1);
      chk("+50 result", 32'(bus0.result), 32'h032);
      chk("+50 model",  32'(m_res[0]), 32'h032);
      do_ack();
      chk("ack drops valid", 32'(bus0.result_valid), 32'h0);
      chk("result held",     32'(bus0.result), 32'h032);

      run4(-3, -3, -3, -3);
      chk("-255 result", 32'(bus0.result), 32'h101);
      do_ack();
      run4(3, 3, 3, 3);
      chk("+255 result", 32'(bus0.result), 32'h0FF);
      do_ack();
      run4(0, 0, 0, -1);
      chk("-1 result", 32'(bus0.result), 32'h1FF);
      do_ack();

      // DELAY=1 with irregular en; junk digits on en=0 cycles must be ignored.
      cyc(1, 0, 0, 0);
      cyc(0, 1, 3, 0);
      cyc(0, 0, 3, 0);
      cyc(0, 0, -3, 0);
      cyc(0, 1, 2, 0);
      cyc(0, 0, 1, 0);
      cyc(0, 1, 0, 0);
      cyc(0, 1, -2, 0);
      cyc(0, 0, 3, 0);
      chk("u1 hold busy",  32'(bus1.busy), 32'h1);
      chk("u1 hold valid", 32'(bus1.result_valid), 32'h0);
      cyc(0, 1, 1, 0);
      cyc(0, 0, 0, 0);
      chk("u1 +121 result", 32'(bus1.result), 32'h079);
      chk("u1 +121 valid",  32'(bus1.result_valid), 32'h1);
      chk("u1 +121 model",  32'(m_res[1]), 32'h079);
      chk("u0 +222 result", 32'(bus0.result), 32'h0DE);
      do_ack();

      // Abort mid-CONV, then restart with start+en in the same cycle.
      cyc(1, 0, 0, 0);
      cyc(0, 1, 3, 0);
      cyc(0, 1, 3, 0);
      cyc(1, 1, 3, 0);
      cyc(0, 1, 1, 0);
      cyc(0, 1, -1, 0);
      cyc(0, 1, 0, 0);
      cyc(0, 1, 2, 0);
      cyc(0, 0, 0, 0);
      chk("restart +50 result", 32'(bus0.result), 32'h032);
      chk("restart +50 valid",  32'(bus0.result_valid), 32'h1);
      do_ack();

      // Illegal digit: flagged, converted as zero.
      run4(1, 4, 0, 0);
      chk("illegal err",    32'(bus0.digit_err), 32'h1);
      chk("illegal result", 32'(bus0.result), 32'h040);
      do_ack();
      chk("err sticky after ack", 32'(bus0.digit_err), 32'h1);
      cyc(1, 0, 0, 0);
      cyc(0, 0, 0, 0);
      chk("start clears err", 32'(bus0.digit_err), 32'h0);

      // Asynchronous reset in the middle of CONV.
      cyc(0, 1, 4, 0);
      cyc(0, 1, 2, 0);
      cyc(0, 0, 0, 0);
      chk("pre-reset err", 32'(bus0.digit_err), 32'h1);
      #2 reset = 1'b1;
      #1;
      chk("async rst result", 32'(bus0.result), 32'h0);
      chk("async rst valid",  32'(bus0.result_valid), 32'h0);
      chk("async rst busy",   32'(bus0.busy), 32'h0);
      chk("async rst err",    32'(bus0.digit_err), 32'h0);
      @(negedge clk);
      reset = 1'b0;
      repeat (2) cyc(0, 0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
